button_press_detector: RTL and testbench

//  Consumes the debounced level from the button debouncer and turns it into

---
 rtl/button_press_detector_if.sv | 27 ++
 rtl/button_press_detector.sv | 130 +++++++++++++
 tb/tb_button_press_detector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/button_press_detector_if.sv
// rtl/button_press_detector_if.sv - button level in, press/release/long/repeat events out
interface button_press_detector_if;
  logic bounce_state;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
  logic held;
  logic repeat_pulse;

  modport master (
    output bounce_state,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  held,
    input  repeat_pulse
  );

  modport slave (
    input  bounce_state,
    output press_pulse,
    output release_pulse,
    output long_press,
    output held,
    output repeat_pulse
  );
endinterface

// File: rtl/button_press_detector.sv
// rtl/button_press_detector.sv - debounced level to single-cycle press/release/long/repeat events
// Auto-repeat while in LONG is built only when BTN_AUTOREPEAT_EN is defined.
module button_press_detector #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16
) (
  input logic                    clk,
  input logic                    rst,
  button_press_detector_if.slave btn
);
  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_LONG} state_t;

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || (longint'(1) << CNT_W) <= longint'(MAX_CYCLES)) begin : g_bad_params
    $error("button_press_detector: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             armed, armed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_q, repeat_d;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    armed_d   = armed;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // A level already high out of reset must be seen low once before it counts.
        if (!btn.bounce_state) begin
          armed_d = 1'b1;
        end else if (armed) begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_W'(1);
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn.bounce_state) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!btn.bounce_state) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      armed     <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= (state_d != ST_IDLE);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign btn.repeat_pulse = repeat_q;
`else
  assign btn.repeat_pulse = 1'b0;
`endif

  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_press    = long_q;
  assign btn.held          = held_q;
endmodule

// File: tb/tb_button_press_detector.sv
// tb/tb_button_press_detector.sv - directed and random stimulus against a hold-length reference model
module tb_button_press_detector;
  localparam int LONG_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_press_detector_if btn ();

  button_press_detector #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: a press is a rising sample while armed; hold_len counts high samples since it.
  bit m_armed   = 1'b0;
  bit m_pressed = 1'b0;
  int hold_len  = 0;
  bit e_press, e_release, e_long, e_repeat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit b);
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
    e_repeat  = 1'b0;
    if (r) begin
      m_armed   = 1'b0;
      m_pressed = 1'b0;
      hold_len  = 0;
    end else if (!m_pressed) begin
      if (!b) begin
        m_armed = 1'b1;
      end else if (m_armed) begin
        m_pressed = 1'b1;
        hold_len  = 1;
        e_press   = 1'b1;
      end
    end else if (!b) begin
      m_pressed = 1'b0;
      hold_len  = 0;
      e_release = 1'b1;
    end else begin
      hold_len++;
      if (hold_len == LONG_CYCLES)
        e_long = 1'b1;
      else if (AUTOREPEAT && hold_len > LONG_CYCLES && (hold_len - LONG_CYCLES) % REPEAT_CYCLES == 0)
        e_repeat = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit b);
    @(negedge clk);
    rst = r;
    btn.bounce_state = b;
    @(posedge clk);
    model_update(r, b);
    #1;
    check("press_pulse",   32'(btn.press_pulse),   32'(e_press));
    check("release_pulse", 32'(btn.release_pulse), 32'(e_release));
    check("long_press",    32'(btn.long_press),    32'(e_long));
    check("repeat_pulse",  32'(btn.repeat_pulse),  32'(e_repeat));
    check("held",          32'(btn.held),          32'(m_pressed));
    check("one_event", 32'($countones({btn.press_pulse, btn.release_pulse, btn.long_press, btn.repeat_pulse}) <= 1), 32'd1);
  endtask

  task automatic run(input bit r, input bit b, input int n);
    for (int i = 0; i < n; i++) step(r, b);
  endtask

  initial begin
    rst = 1'b1;
    btn.bounce_state = 1'b0;

    // short press, no long
    run(1, 0, 2);
    run(0, 0, 10);
    run(0, 1, 3);
    run(0, 0, 3);

    // long hold with possible repeats
    run(0, 1, 20);
    run(0, 0, 3);

    // held through reset: needs a low before it counts
    run(1, 1, 2);
    run(0, 1, 5);
    run(0, 0, 1);
    run(0, 1, 3);
    run(0, 0, 2);

    // release on the edge that would have given long_press, then one hold past it
    run(0, 1, LONG_CYCLES - 1);
    run(0, 0, 2);
    run(0, 1, LONG_CYCLES);
    run(0, 0, 2);

    // reset while in LONG
    run(0, 1, 12);
    run(1, 1, 1);
    run(0, 1, 3);
    run(0, 0, 1);
    run(0, 1, 3);
    run(0, 0, 2);

    // alternating single-cycle levels
    for (int i = 0; i < 20; i++) step(0, i[0]);

    // random runs with occasional reset
    for (int k = 0; k < 60; k++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0)) ? int'($urandom_range(8, 24)) : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) step($urandom_range(0, 99) == 0, lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
